// File: rtl/alu_seq_if.sv
// ****************************************************************************
// * Module : alu_seq_if
// * Brief  : Requester, ALU and result bundle for the alu_seq sequencer.
// * Rev    : 1.0
// ****************************************************************************
`default_nettype none
`timescale 1ns/1ps

interface alu_seq_if;
  logic       in0_valid;
  logic       in1_valid;
  logic       in0_ready;
  logic       in1_ready;
  logic [3:0] in0_op;
  logic [3:0] in1_op;
  logic [3:0] in0_a;
  logic [3:0] in0_b;
  logic [3:0] in1_a;
  logic [3:0] in1_b;
  logic       in0_cin;
  logic       in1_cin;
  logic [1:0] in0_cnt;
  logic [1:0] in1_cnt;

  logic [3:0] alu_s;
  logic       alu_cin;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_f;
  logic       alu_cout;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_f;
  logic       out_cout;
  logic       out_id;

  // Sequencer side
  modport slave (
    input  in0_valid, in1_valid, in0_op, in1_op, in0_a, in0_b, in1_a, in1_b,
           in0_cin, in1_cin, in0_cnt, in1_cnt, alu_f, alu_cout, out_ready,
    output in0_ready, in1_ready, alu_s, alu_cin, alu_a, alu_b,
           out_valid, out_f, out_cout, out_id
  );

  // Requesters, external ALU and result consumer
  modport master (
    output in0_valid, in1_valid, in0_op, in1_op, in0_a, in0_b, in1_a, in1_b,
           in0_cin, in1_cin, in0_cnt, in1_cnt, alu_f, alu_cout, out_ready,
    input  in0_ready, in1_ready, alu_s, alu_cin, alu_a, alu_b,
           out_valid, out_f, out_cout, out_id
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ****************************************************************************
// * Module : alu_seq
// * Brief  : Two-requester command sequencer driving an external 4-bit ALU,
// *          with multi-cycle shifts. ALU_SEQ_FIXED_PRI_EN: requester 0 always
// *          wins conflicts (default: round-robin starting at RR_INIT).
// * Rev    : 1.0
// ****************************************************************************
`default_nettype none
`timescale 1ns/1ps

module alu_seq #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_cin;
  logic [1:0] cmd_left;
  logic       cmd_id;
  logic [3:0] res_f;
  logic       res_cout;

  logic       grant0;
  logic       grant1;
  logic       can_grant;
  logic       accept;
  logic       win_id;
  logic       last_step;

`ifdef ALU_SEQ_FIXED_PRI_EN
  assign grant0 = bus.in0_valid;
  assign grant1 = bus.in1_valid & ~bus.in0_valid;
`else
  logic pri;

  assign grant0 = bus.in0_valid & (~bus.in1_valid | ~pri);
  assign grant1 = bus.in1_valid & (~bus.in0_valid |  pri);

  // Priority moves to the requester that just lost (or did not compete)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri <= (RR_INIT != 0);
    end else if (accept) begin
      pri <= ~win_id;
    end
  end
`endif

  // Grants are suppressed while reset is held so ready reads low immediately
  assign can_grant     = rst_n & (state == IDLE);
  assign bus.in0_ready = can_grant & grant0;
  assign bus.in1_ready = can_grant & grant1;
  assign accept        = bus.in0_ready | bus.in1_ready;
  assign win_id        = bus.in1_ready;

  assign last_step = ~cmd_op[3] | (cmd_left == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.alu_s     = 4'd0;
    bus.alu_cin   = 1'b0;
    bus.alu_a     = 4'd0;
    bus.alu_b     = 4'd0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = EXEC;
      end
      EXEC, SHIFT: begin
        bus.alu_s   = cmd_op;
        bus.alu_cin = cmd_cin;
        bus.alu_a   = cmd_a;
        bus.alu_b   = cmd_b;
        state_nx    = last_step ? DONE : SHIFT;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // cmd_a doubles as the running shift operand; results latch on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_op   <= 4'd0;
      cmd_a    <= 4'd0;
      cmd_b    <= 4'd0;
      cmd_cin  <= 1'b0;
      cmd_left <= 2'd0;
      cmd_id   <= 1'b0;
      res_f    <= 4'd0;
      res_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_op   <= win_id ? bus.in1_op  : bus.in0_op;
            cmd_a    <= win_id ? bus.in1_a   : bus.in0_a;
            cmd_b    <= win_id ? bus.in1_b   : bus.in0_b;
            cmd_cin  <= win_id ? bus.in1_cin : bus.in0_cin;
            cmd_left <= win_id ? bus.in1_cnt : bus.in0_cnt;
            cmd_id   <= win_id;
          end
        end
        EXEC, SHIFT: begin
          cmd_a <= bus.alu_f;
          if (last_step) begin
            res_f    <= bus.alu_f;
            res_cout <= bus.alu_cout;
          end else begin
            cmd_left <= cmd_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_f    = res_f;
  assign bus.out_cout = res_cout;
  assign bus.out_id   = cmd_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ****************************************************************************
// * Module : tb_alu_seq
// * Brief  : Scoreboard bench for alu_seq with an external ALU and reference.
// * Rev    : 1.0
// ****************************************************************************
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq;

  localparam int RR_INIT_TB = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if bus();

  alu_seq #(.RR_INIT(RR_INIT_TB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ALU behaviour: returns {cout, f}
  function automatic logic [4:0] alu_fn(input logic [3:0] s, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    logic [4:0] r;
    r = 5'd0;
    if (s[3]) begin
      if (s[2]) r = {a[3], a[2:0], cin};
      else      r = {a[0], cin, a[3:1]};
    end else if (s[2]) begin
      case (s[1:0])
        2'd0:    r = {1'b0, a & b};
        2'd1:    r = {1'b0, a | b};
        2'd2:    r = {1'b0, a ^ b};
        default: r = {1'b0, ~a};
      endcase
    end else begin
      case (s[1:0])
        2'd0:    r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        2'd1:    r = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        2'd2:    r = {1'b0, a} + {4'd0, cin};
        default: r = {1'b0, a} + 5'h0F + {4'd0, cin};
      endcase
    end
    return r;
  endfunction

  logic [4:0] alu_res;
  always_comb alu_res = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b, bus.alu_cin);
  assign bus.alu_f    = alu_res[3:0];
  assign bus.alu_cout = alu_res[4];

  // Whole-command reference: apply the select cnt+1 times for shifts, once otherwise
  function automatic logic [4:0] ref_result(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin,
                                            input logic [1:0] cnt);
    int n;
    logic [3:0] x;
    logic [4:0] r;
    n = op[3] ? int'(cnt) + 1 : 1;
    x = a;
    r = 5'd0;
    for (int i = 0; i < n; i++) begin
      r = alu_fn(op, x, b, cin);
      x = r[3:0];
    end
    return r;
  endfunction

  typedef struct {
    logic [3:0] f;
    logic       c;
    logic       id;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   pri_m = (RR_INIT_TB != 0);
  bit   acc[2];
  logic [3:0] last_f;
  logic       last_id;
  int         last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard
  bit         hold_prev = 1'b0;
  bit         v_prev = 1'b0;
  int         first_vcyc = 0;
  logic [3:0] hold_f;
  logic       hold_c;
  logic       hold_id;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pri_m     = (RR_INIT_TB != 0);
      hold_prev = 1'b0;
      v_prev    = 1'b0;
    end else begin
      logic       w;
      logic [3:0] op, a, b;
      logic       cin;
      logic [1:0] cnt;
      logic [4:0] r;
      exp_t       e;
      if (bus.in0_ready && bus.in1_ready) fail("double_grant");
      if (!bus.in0_valid) chk("ready0_without_valid", bus.in0_ready, 0);
      if (!bus.in1_valid) chk("ready1_without_valid", bus.in1_ready, 0);
      if (bus.out_valid) chk("grant_while_done", {bus.in0_ready, bus.in1_ready}, 0);
      if (bus.in0_ready || bus.in1_ready) begin
        w = bus.in1_ready;
        if (bus.in0_valid && bus.in1_valid) begin
`ifdef ALU_SEQ_FIXED_PRI_EN
          chk("arb_winner", w, 0);
`else
          chk("arb_winner", w, pri_m);
`endif
        end
        pri_m = ~w;
        grant_log.push_back(int'(w));
        op  = w ? bus.in1_op  : bus.in0_op;
        a   = w ? bus.in1_a   : bus.in0_a;
        b   = w ? bus.in1_b   : bus.in0_b;
        cin = w ? bus.in1_cin : bus.in0_cin;
        cnt = w ? bus.in1_cnt : bus.in0_cnt;
        r   = ref_result(op, a, b, cin, cnt);
        sb.push_back('{f: r[3:0], c: r[4], id: w,
                       lat: (op[3] ? int'(cnt) + 2 : 2), acc: cyc});
        acc[w] = 1'b1;
      end
      if (bus.out_valid) begin
        if (!v_prev) first_vcyc = cyc;
        if (hold_prev) begin
          chk("hold_f", bus.out_f, hold_f);
          chk("hold_cout", bus.out_cout, hold_c);
          chk("hold_id", bus.out_id, hold_id);
        end
        if (sb.size() == 0) begin
          fail("unexpected_out_valid");
        end else if (bus.out_ready) begin
          e = sb.pop_front();
          chk("out_f", bus.out_f, e.f);
          chk("out_cout", bus.out_cout, e.c);
          chk("out_id", bus.out_id, e.id);
          chk("latency", first_vcyc - e.acc, e.lat);
          last_f   = bus.out_f;
          last_id  = bus.out_id;
          last_lat = first_vcyc - e.acc;
        end
        hold_prev = !bus.out_ready;
        hold_f    = bus.out_f;
        hold_c    = bus.out_cout;
        hold_id   = bus.out_id;
      end else begin
        hold_prev = 1'b0;
      end
      v_prev = bus.out_valid && !bus.out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic cin, input logic [1:0] cnt);
    if (r == 0) begin
      bus.in0_op = op; bus.in0_a = a; bus.in0_b = b; bus.in0_cin = cin; bus.in0_cnt = cnt;
      bus.in0_valid = 1'b1;
    end else begin
      bus.in1_op = op; bus.in1_a = a; bus.in1_b = b; bus.in1_cin = cin; bus.in1_cnt = cnt;
      bus.in1_valid = 1'b1;
    end
  endtask

  task automatic drop(input int r);
    if (r == 0) bus.in0_valid = 1'b0;
    else        bus.in1_valid = 1'b0;
  endtask

  task automatic rand_cmd(input int r, input bit nonshift);
    logic [3:0] op;
    op = 4'($urandom);
    if (nonshift) op[3] = 1'b0;
    set_cmd(r, op, 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
  endtask

  // Returns in the cycle after the accepting edge (EXEC)
  task automatic issue(input int r, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic cin, input logic [1:0] cnt);
    acc[r] = 1'b0;
    set_cmd(r, op, a, b, cin, cnt);
    for (int i = 0; i < 100 && !acc[r]; i++) tick();
    if (!acc[r]) fail("issue_timeout");
    acc[r] = 1'b0;
    drop(r);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    if (sb.size() != 0) fail("drain_timeout");
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_f"}, bus.out_f, 0);
    chk({tag, "_out_cout"}, bus.out_cout, 0);
    chk({tag, "_out_id"}, bus.out_id, 0);
    chk({tag, "_ready"}, {bus.in0_ready, bus.in1_ready}, 0);
    chk({tag, "_alu_s"}, bus.alu_s, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_cin"}, bus.alu_cin, 0);
  endtask

  initial begin
    logic [4:0] step1;
    int         exp_g;
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0; bus.out_ready = 1'b0;
    set_cmd(0, 4'hD, 4'hF, 4'hF, 1'b1, 2'd3);
    set_cmd(1, 4'hC, 4'hA, 4'h5, 1'b1, 2'd1);

    // Reset state with both requesters asserting valid
    #2;
    check_all_zero("reset");
    tick();
    tick();
    check_all_zero("reset_held");
    drop(0);
    drop(1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Three-step right shift
    issue(0, 4'b1000, 4'b1000, 4'h0, 1'b0, 2'd2);
    drain(20);
    chk("shr_f", last_f, 4'b0001);
    chk("shr_id", last_id, 0);
    chk("shr_lat", last_lat, 4);

    // Single-step left shift from requester 1
    issue(1, 4'b1100, 4'b0011, 4'h0, 1'b0, 2'd0);
    drain(20);
    chk("shl_f", last_f, 4'b0110);
    chk("shl_id", last_id, 1);
    chk("shl_lat", last_lat, 2);

    // Back-pressure in DONE while requester 1 waits
    bus.out_ready = 1'b0;
    issue(0, 4'b0000, 4'h9, 4'h8, 1'b1, 2'd0);
    set_cmd(1, 4'b0101, 4'h3, 4'hC, 1'b0, 2'd0);
    acc[1] = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    chk("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_valid_held", bus.out_valid, 1);
    chk("bp_no_grant", acc[1], 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_released", bus.out_valid, 0);
    chk("bp_idle_grant", bus.in1_ready, 1);
    tick();
    chk("bp_in1_accepted", acc[1], 1);
    drop(1);
    acc[1] = 1'b0;
    drain(20);

    // Asynchronous reset in the middle of a four-step shift
    issue(0, 4'b1100, 4'b0011, 4'h6, 1'b1, 2'd3);
    chk("exec_alu_s", bus.alu_s, 4'b1100);
    chk("exec_alu_a", bus.alu_a, 4'b0011);
    chk("exec_alu_b", bus.alu_b, 4'h6);
    chk("exec_alu_cin", bus.alu_cin, 1);
    step1 = alu_fn(4'b1100, 4'b0011, 4'h6, 1'b1);
    tick();
    chk("shift_alu_a", bus.alu_a, step1[3:0]);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midshift_reset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    issue(1, 4'b0001, 4'h7, 4'h2, 1'b1, 2'd0);
    drain(20);
    chk("post_reset_id", last_id, 1);
    chk("post_reset_lat", last_lat, 2);

    // Both requesters valid every cycle from a fresh reset
    pulse_reset();
    grant_log.delete();
    rand_cmd(0, 1'b1);
    rand_cmd(1, 1'b1);
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          acc[r] = 1'b0;
          rand_cmd(r, 1'b1);
        end
      end
    end
    drop(0);
    drop(1);
    if (grant_log.size() < 4) fail("rr_grant_count");
    else begin
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_SEQ_FIXED_PRI_EN
        exp_g = 0;
`else
        exp_g = i % 2;
`endif
        chk($sformatf("grant_seq_%0d", i), grant_log[i], exp_g);
      end
    end
    drain(40);

    // Randomized traffic with back-pressure and abandoned requests
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          acc[r] = 1'b0;
          drop(r);
        end
        if (!(r == 0 ? bus.in0_valid : bus.in1_valid)) begin
          if ($urandom_range(0, 9) < 4) rand_cmd(r, 1'b0);
        end else if ($urandom_range(0, 9) == 0) begin
          drop(r);
        end
      end
      tick();
    end
    drop(0);
    drop(1);
    bus.out_ready = 1'b1;
    tick();
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
